// File: rtl/picmicro_pc_sequencer.sv
// picmicro_pc_sequencer
//   Program-counter and return-stack sequencer for the PIC midrange core.
//   Generates the four-phase Q-cycle timing, addresses program memory and
//   applies GOTO/CALL/RETURN/SKIP with a one-instruction pipeline flush.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-high reset
//   stall        in   freezes all state while high
//   op           in   flow op of the executing instruction, sampled at Q4
//                     (0 NEXT, 1 GOTO, 2 CALL, 3 RETURN, 4 SKIP, 5..7 NEXT)
//   target       in   GOTO/CALL destination (PCLATH already merged)
//   clr_flags    in   synchronous clear of stack_ovf / stack_unf
//   q_phase      out  current Q cycle, 0=Q1 .. 3=Q4
//   instr_rd_en  out  program-memory capture strobe (combinational)
//   pc_out       out  address of the next instruction to fetch
//   flush        out  executing instruction must be treated as NOP
//   stack_count  out  number of valid return-stack entries
//   stack_ovf    out  sticky: push while stack full
//   stack_unf    out  sticky: pop while stack empty
//
// Q-phase states
//   state | meaning
//   Q1    | first clock of the instruction cycle
//   Q2    | second clock
//   Q3    | third clock
//   Q4    | last clock; fetch captured and flow op applied on its edge

module picmicro_pc_sequencer #(
  parameter int unsigned PC_WIDTH     = 13,
  parameter int unsigned STACK_DEPTH  = 8,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stall,
  input  logic [2:0]                       op,
  input  logic [PC_WIDTH-1:0]              target,
  input  logic                             clr_flags,
  output logic [1:0]                       q_phase,
  output logic                             instr_rd_en,
  output logic [PC_WIDTH-1:0]              pc_out,
  output logic                             flush,
  output logic [$clog2(STACK_DEPTH):0]     stack_count,
  output logic                             stack_ovf,
  output logic                             stack_unf
);

  localparam int unsigned SPW = $clog2(STACK_DEPTH);
  localparam int unsigned CW  = SPW + 1;

  localparam logic [CW-1:0]       CNT_FULL = CW'(STACK_DEPTH);
  localparam logic [PC_WIDTH-1:0] RST_PC   = PC_WIDTH'(RESET_VECTOR);

  localparam logic [2:0] OP_GOTO   = 3'd1;
  localparam logic [2:0] OP_CALL   = 3'd2;
  localparam logic [2:0] OP_RETURN = 3'd3;
  localparam logic [2:0] OP_SKIP   = 3'd4;

  typedef enum logic [1:0] {
    Q1 = 2'd0,
    Q2 = 2'd1,
    Q3 = 2'd2,
    Q4 = 2'd3
  } qphase_e;

  qphase_e               phase_q, phase_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  flush_q, flush_d;
  logic [SPW-1:0]        sp_q, sp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  push;
  logic [PC_WIDTH-1:0]   tos;

  // Return-stack storage is deliberately not reset; only pointer/count are.
  logic [PC_WIDTH-1:0]   stack_mem [STACK_DEPTH];

  // Entry just below the write pointer; on an empty stack this wraps to the
  // stale entry, which is the PIC-compatible underflow behaviour.
  assign tos = stack_mem[sp_q - SPW'(1)];

  always_comb begin
    phase_d = qphase_e'(phase_q + 2'd1);
    pc_d    = pc_q;
    flush_d = flush_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q & ~clr_flags;
    unf_d   = unf_q & ~clr_flags;
    push    = 1'b0;

    if (phase_q == Q4) begin
      pc_d    = pc_q + PC_WIDTH'(1);
      flush_d = 1'b0;
      // A flushed instruction is a NOP regardless of what the decoder says.
      if (!flush_q) begin
        case (op)
          OP_GOTO: begin
            pc_d    = target;
            flush_d = 1'b1;
          end
          OP_CALL: begin
            push    = 1'b1;
            pc_d    = target;
            flush_d = 1'b1;
            sp_d    = sp_q + SPW'(1);
            if (cnt_q == CNT_FULL) ovf_d = 1'b1;
            else                   cnt_d = cnt_q + CW'(1);
          end
          OP_RETURN: begin
            pc_d    = tos;
            flush_d = 1'b1;
            sp_d    = sp_q - SPW'(1);
            if (cnt_q == '0) unf_d = 1'b1;
            else             cnt_d = cnt_q - CW'(1);
          end
          OP_SKIP: begin
            flush_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= Q1;
      pc_q    <= RST_PC;
      flush_q <= 1'b1;
      sp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (!stall) begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // push is only ever set in Q4, which reset forces away from, so a reset
  // during a CALL cycle cannot write the stack.
  always_ff @(posedge clk) begin
    if (!stall && push) stack_mem[sp_q] <= pc_q;
  end

  assign q_phase     = phase_q;
  assign instr_rd_en = (phase_q == Q4) && !stall;
  assign pc_out      = pc_q;
  assign flush       = flush_q;
  assign stack_count = cnt_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

endmodule

// File: tb/tb_picmicro_pc_sequencer.sv
module tb_picmicro_pc_sequencer;

  localparam int PCW = 13;

  logic           clk;
  logic           rst;
  logic           stall;
  logic [2:0]     op;
  logic [PCW-1:0] target;
  logic           clr_flags;
  logic [1:0]     q_phase;
  logic           instr_rd_en;
  logic [PCW-1:0] pc_out;
  logic           flush;
  logic [3:0]     stack_count;
  logic           stack_ovf;
  logic           stack_unf;

  int n_assert = 0;
  int n_fail   = 0;

  logic [PCW-1:0] fetch_q[$];

  picmicro_pc_sequencer #(
    .PC_WIDTH(PCW),
    .STACK_DEPTH(8),
    .RESET_VECTOR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .op(op),
    .target(target),
    .clr_flags(clr_flags),
    .q_phase(q_phase),
    .instr_rd_en(instr_rd_en),
    .pc_out(pc_out),
    .flush(flush),
    .stack_count(stack_count),
    .stack_ovf(stack_ovf),
    .stack_unf(stack_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] NEXT = 3'd0, GOTO = 3'd1, CALL = 3'd2, RET = 3'd3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fetch scoreboard: every capture strobe must present the next expected address.
  always @(negedge clk) begin
    if (rst === 1'b0 && instr_rd_en === 1'b1) begin
      n_assert++;
      if (fetch_q.size() == 0) begin
        n_fail++;
        $error("FAIL fetch_unexpected: observed %0h expected none", pc_out);
      end else begin
        logic [PCW-1:0] e;
        e = fetch_q.pop_front();
        assert (pc_out === e)
        else begin
          n_fail++;
          $error("FAIL fetch_addr: observed %0h expected %0h", pc_out, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction cycle, entered at Q1. Checks the cycle-start state and
  // the phase sequence, and records the address this cycle will fetch.
  task automatic cyc(input logic [2:0] o, input logic [PCW-1:0] t,
                     input logic [PCW-1:0] exp_pc, input logic exp_fl, input string tag);
    op = o;
    target = t;
    chk({tag, "_pc"}, pc_out, exp_pc);
    chk({tag, "_flush"}, flush, exp_fl);
    chk({tag, "_q1"}, q_phase, 0);
    fetch_q.push_back(exp_pc);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk({tag, "_qphase"}, q_phase, i);
    end
    chk({tag, "_rden_q4"}, instr_rd_en, 1);
    tick();
  endtask

  logic [PCW-1:0] p [1:9];
  logic [PCW-1:0] cur;

  initial begin
    rst = 1'b1; stall = 1'b0; op = NEXT; target = '0; clr_flags = 1'b0;
    tick();
    tick();
    chk("rst_q", q_phase, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_flush", flush, 1);
    chk("rst_rden", instr_rd_en, 0);
    chk("rst_cnt", stack_count, 0);
    chk("rst_ovf", stack_ovf, 0);
    chk("rst_unf", stack_unf, 0);
    rst = 1'b0;

    // Straight-line fetch after reset
    cyc(NEXT, 0, 13'h000, 1, "seq0");
    cyc(NEXT, 0, 13'h001, 0, "seq1");
    cyc(NEXT, 0, 13'h002, 0, "seq2");
    cyc(NEXT, 0, 13'h003, 0, "seq3");
    cyc(NEXT, 0, 13'h004, 0, "seq4");

    // GOTO, then a CALL in the flushed cycle that must be ignored
    cyc(GOTO, 13'h1A5, 13'h005, 0, "goto");
    cyc(CALL, 13'h077, 13'h1A5, 1, "goto_fl");
    chk("goto_nopush", stack_count, 0);
    cyc(NEXT, 0, 13'h1A6, 0, "goto_after");

    // CALL / RETURN
    cyc(GOTO, 13'h020, 13'h1A7, 0, "g20");
    cyc(NEXT, 0, 13'h020, 1, "g20_fl");
    cyc(CALL, 13'h100, 13'h021, 0, "call");
    chk("call_cnt", stack_count, 1);
    cyc(NEXT, 0, 13'h100, 1, "call_fl");
    cyc(RET, 0, 13'h101, 0, "ret");
    chk("ret_cnt", stack_count, 0);
    cyc(NEXT, 0, 13'h021, 1, "ret_fl");
    cyc(NEXT, 0, 13'h022, 0, "ret_after");

    // Nine nested calls on an eight-deep stack
    cur = 13'h023;
    for (int k = 1; k <= 9; k++) begin
      logic [PCW-1:0] tk;
      tk = PCW'(13'h200 + 13'h10 * k);
      p[k] = cur;
      cyc(CALL, tk, cur, 0, $sformatf("ncall%0d", k));
      chk($sformatf("ncall%0d_cnt", k), stack_count, (k > 8) ? 8 : k);
      chk($sformatf("ncall%0d_ovf", k), stack_ovf, (k == 9) ? 1 : 0);
      cyc(NEXT, 0, tk, 1, $sformatf("ncall%0d_fl", k));
      cur = tk + 1'b1;
    end

    for (int j = 1; j <= 8; j++) begin
      cyc(RET, 0, cur, 0, $sformatf("nret%0d", j));
      chk($sformatf("nret%0d_cnt", j), stack_count, 8 - j);
      chk($sformatf("nret%0d_unf", j), stack_unf, 0);
      cyc(NEXT, 0, p[10 - j], 1, $sformatf("nret%0d_fl", j));
      cur = p[10 - j] + 1'b1;
    end
    cyc(RET, 0, cur, 0, "uret");
    chk("uret_cnt", stack_count, 0);
    chk("uret_unf", stack_unf, 1);
    chk("uret_ovf", stack_ovf, 1);
    cyc(NEXT, 0, p[9], 1, "uret_fl");
    cur = p[9] + 1'b1;

    // Flag clear, then set-wins on a simultaneous underflow
    clr_flags = 1'b1;
    cyc(NEXT, 0, cur, 0, "clr");
    chk("clr_ovf", stack_ovf, 0);
    chk("clr_unf", stack_unf, 0);
    cur = cur + 1'b1;
    cyc(RET, 0, cur, 0, "clr_uret");
    clr_flags = 1'b0;
    chk("setwins_unf", stack_unf, 1);
    chk("setwins_ovf", stack_ovf, 0);
    chk("setwins_cnt", stack_count, 0);
    cyc(NEXT, 0, p[8], 1, "stale_ret");
    cur = p[8] + 1'b1;

    // Stall held for seven clocks at Q3 (q_phase 2)
    op = NEXT;
    fetch_q.push_back(cur);
    tick();
    tick();
    chk("pre_stall_q", q_phase, 2);
    stall = 1'b1;
    #1;
    chk("stall_rden0", instr_rd_en, 0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("stall%0d_q", i), q_phase, 2);
      chk($sformatf("stall%0d_pc", i), pc_out, cur);
      chk($sformatf("stall%0d_rden", i), instr_rd_en, 0);
      chk($sformatf("stall%0d_flush", i), flush, 0);
    end
    stall = 1'b0;
    tick();
    chk("resume_q", q_phase, 3);
    chk("resume_rden", instr_rd_en, 1);
    tick();
    cur = cur + 1'b1;

    // Reset in Q4 of a CALL cycle with a non-empty stack
    cyc(CALL, 13'h050, cur, 0, "pre_rst_call");
    chk("pre_rst_cnt", stack_count, 1);
    cyc(NEXT, 0, 13'h050, 1, "pre_rst_fl");
    op = CALL;
    target = 13'h333;
    tick();
    tick();
    tick();
    chk("rst_mid_qpre", q_phase, 3);
    rst = 1'b1;
    #1;
    chk("rst_mid_pc", pc_out, 0);
    chk("rst_mid_cnt", stack_count, 0);
    chk("rst_mid_q", q_phase, 0);
    chk("rst_mid_flush", flush, 1);
    tick();
    rst = 1'b0;
    cyc(NEXT, 0, 13'h000, 1, "post_rst0");
    cyc(NEXT, 0, 13'h001, 0, "post_rst1");
    chk("post_rst_cnt", stack_count, 0);
    chk("post_rst_ovf", stack_ovf, 0);

    tick();
    chk("fetch_q_drained", fetch_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
